// File: rtl/ov7670_cfg_sequencer_pkg.sv
// ov7670_cfg_pkg: shared types and constants for the OV7670 configuration sequencer.
//   state_e        sequencer FSM states
//   CFG_END        ROM control word that terminates the table
//   CFG_DELAY      ROM control word that inserts a long settle delay
//   max3 / ld_val  helpers for sizing the wait timer and computing load values
package ov7670_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT_DONE,
        GAP,
        DELAY,
        NEXT,
        FINISH
    } state_e;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The timer is checked for expiry in the same cycle it reaches zero, so an
    // interval of n cycles is loaded as n-1. Zero-length intervals take one cycle.
    function automatic int ld_val(input int n);
        return (n > 0) ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/ov7670_cfg_sequencer_if.sv
// ov7670_cfg_sequencer_if: byte-write handshake between the config sequencer
// and the SCCB engine.
//   wr_valid     sequencer -> engine, request pending
//   wr_ready     engine -> sequencer, request accepted on valid&ready
//   wr_reg_addr  register address, stable while wr_valid
//   wr_data      register value, stable while wr_valid
//   wr_done      engine -> sequencer, one-cycle pulse when the write completes
interface ov7670_cfg_sequencer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_reg_addr;
    logic [7:0] wr_data;
    logic       wr_done;

    modport master (
        output wr_valid, wr_reg_addr, wr_data,
        input  wr_ready, wr_done
    );

    modport slave (
        input  wr_valid, wr_reg_addr, wr_data,
        output wr_ready, wr_done
    );
endinterface

// File: rtl/ov7670_cfg_sequencer_timer.sv
// cfg_wait_timer: loadable down-counter that stops at zero.
//   clk_100MHz  clock
//   reset       asynchronous, active-high reset (counter -> 0)
//   load        load load_val this cycle (takes priority over counting)
//   load_val    value to load
//   expired     counter is at zero
// The sequencer reuses one instance for every interval, loading it on entry
// to each timed state, so it simply free-runs down between loads.
module cfg_wait_timer #(
    parameter int W = 21
) (
    input  logic         clk_100MHz,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// ov7670_cfg_sequencer: walks the OV7670 configuration ROM and issues each
// {reg_addr, value} word to the SCCB byte-write engine.
//   clk_100MHz   system clock
//   reset        asynchronous, active-high reset
//   start        one-cycle pulse starting a configuration pass (ignored while busy)
//   rom_addr     registered ROM address
//   rom_data     registered ROM word {reg_addr, value}; 16'hFFF0 = delay, 16'hFFFF = end
//   wr           write handshake to the SCCB engine (master side)
//   busy         high from accepted start until done or timeout abort
//   done         one-cycle pulse on normal end of pass
//   timeout_err  sticky, set when a write is not completed in time
//   write_count  writes completed in the current or last pass
module ov7670_cfg_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int DELAY_CYCLES   = 1_000_000,
    parameter int GAP_CYCLES     = 25_000,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int ROM_AW         = 8
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  start,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [15:0]           rom_data,
    ov7670_cfg_sequencer_if.master wr,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [ROM_AW:0]       write_count
);

    localparam int MAXC = max3(DELAY_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int TW   = $clog2(MAXC + 1);

    // FETCH lasts two cycles so the registered ROM output is valid in DECODE.
    localparam logic [TW-1:0] FETCH_LD = TW'(1);
    localparam logic [TW-1:0] GAP_LD   = TW'(ld_val(GAP_CYCLES));
    localparam logic [TW-1:0] DELAY_LD = TW'(ld_val(DELAY_CYCLES));
    localparam logic [TW-1:0] TO_LD    = TW'(ld_val(TIMEOUT_CYCLES));

    state_e        state;
    logic          wr_valid_q;
    logic [7:0]    wr_reg_addr_q;
    logic [7:0]    wr_data_q;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_exp;
    logic          last_addr;

    assign wr.wr_valid    = wr_valid_q;
    assign wr.wr_reg_addr = wr_reg_addr_q;
    assign wr.wr_data     = wr_data_q;
    assign last_addr      = &rom_addr;

    cfg_wait_timer #(.W(TW)) u_timer (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .expired    (tmr_exp)
    );

    // Timer is loaded on the edge that enters a timed state. The timeout
    // window is loaded on the edge that raises wr_valid and covers both
    // ISSUE and WAIT_DONE.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: if (start) begin
                tmr_load = 1'b1;
                tmr_val  = FETCH_LD;
            end
            DECODE: begin
                if (rom_data == CFG_DELAY) begin
                    tmr_load = 1'b1;
                    tmr_val  = DELAY_LD;
                end else if (rom_data != CFG_END) begin
                    tmr_load = 1'b1;
                    tmr_val  = TO_LD;
                end
            end
            WAIT_DONE: if (wr.wr_done) begin
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            NEXT: if (!last_addr) begin
                tmr_load = 1'b1;
                tmr_val  = FETCH_LD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rom_addr      <= '0;
            wr_valid_q    <= 1'b0;
            wr_reg_addr_q <= '0;
            wr_data_q     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            write_count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rom_addr    <= '0;
                    write_count <= '0;
                    timeout_err <= 1'b0;
                    busy        <= 1'b1;
                    state       <= FETCH;
                end
                FETCH: if (tmr_exp) state <= DECODE;
                DECODE: begin
                    if (rom_data == CFG_END) begin
                        state <= FINISH;
                    end else if (rom_data == CFG_DELAY) begin
                        state <= DELAY;
                    end else begin
                        wr_reg_addr_q <= rom_data[15:8];
                        wr_data_q     <= rom_data[7:0];
                        wr_valid_q    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                // wr_done is deliberately not looked at before acceptance.
                ISSUE: begin
                    if (tmr_exp) begin
                        timeout_err <= 1'b1;
                        wr_valid_q  <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (wr.wr_ready) begin
                        wr_valid_q <= 1'b0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (wr.wr_done) begin
                        if (write_count != '1) write_count <= write_count + 1'b1;
                        state <= GAP;
                    end else if (tmr_exp) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                GAP:   if (tmr_exp) state <= NEXT;
                DELAY: if (tmr_exp) state <= NEXT;
                // Running off the top of the ROM ends the pass like CFG_END.
                NEXT: begin
                    if (last_addr) begin
                        state <= FINISH;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= FETCH;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
